mem_arbiter: RTL and testbench

Single-port arbiter for the shared synchronous instruction/data/video SRAM.
- Three requesters share the one memory port: VGA scanout, CPU load/store unit, and the fetch unit.
- Each cycle it selects one requester, drives the memory port, and returns read data to that requester one cycle later.
- VGA has fixed top priority because scanout is hard real-time.
- Data normally beats fetch; a starvation counter guarantees fetch forward progress.

---
 rtl/mem_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Single-port arbiter for the shared synchronous instruction/data/video SRAM.
// Three requesters (VGA scanout, CPU load/store, instruction fetch) share the
// one memory port. Arbitration is combinational in the request cycle; read data
// comes back to the winning requester one cycle after its grant.
//
// Priority: VGA > starved fetch > data > fetch. A saturating counter tracks
// how many consecutive cycles fetch has been denied; once it reaches
// STARVE_LIMIT, fetch is promoted above data (never above VGA).
//
// Ports:
//   clk, rst_async           clock, asynchronous active-high reset
//   vga_req/addr             VGA read request          -> vga_gnt/rvalid/rdata
//   data_req/we/addr/wdata/be load/store request       -> data_gnt/rvalid/rdata
//   fetch_req/addr           instruction read request  -> fetch_gnt/rvalid/rdata
//   mem_en/we/be/addr/wdata  memory command port (driven by the winner)
//   mem_rdata                memory read data, valid the cycle after the address
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int ADDR_W       = 13,
    parameter int DATA_W       = 16,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_async,

    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic              vga_gnt,
    output logic              vga_rvalid,
    output logic [DATA_W-1:0] vga_rdata,

    input  logic              data_req,
    input  logic              data_we,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    input  logic [1:0]        data_be,
    output logic              data_gnt,
    output logic              data_rvalid,
    output logic [DATA_W-1:0] data_rdata,

    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_gnt,
    output logic              fetch_rvalid,
    output logic [DATA_W-1:0] fetch_rdata,

    output logic              mem_en,
    output logic              mem_we,
    output logic [1:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    // Owner of the read whose data returns in the current cycle.
    localparam logic [1:0] OWN_NONE  = 2'd0;
    localparam logic [1:0] OWN_VGA   = 2'd1;
    localparam logic [1:0] OWN_DATA  = 2'd2;
    localparam logic [1:0] OWN_FETCH = 2'd3;

    logic [CNT_W-1:0] starve_cnt_q;
    logic [CNT_W-1:0] starve_cnt_d;
    logic [1:0]       owner_q;
    logic [1:0]       owner_d;

    logic starved_s;
    logic vga_win_s;
    logic data_win_s;
    logic fetch_win_s;

    assign starved_s = (starve_cnt_q == CNT_MAX);

    // Priority selection; grants are forced low while reset is asserted so
    // every output reads 0 during reset even though requests may be high.
    always_comb begin
        vga_win_s   = 1'b0;
        data_win_s  = 1'b0;
        fetch_win_s = 1'b0;
        if (rst_async) begin
            vga_win_s = 1'b0;
        end else if (vga_req) begin
            vga_win_s = 1'b1;
        end else if (fetch_req && starved_s) begin
            fetch_win_s = 1'b1;
        end else if (data_req) begin
            data_win_s = 1'b1;
        end else if (fetch_req) begin
            fetch_win_s = 1'b1;
        end else begin
            vga_win_s = 1'b0;
        end
    end

    assign vga_gnt   = vga_win_s;
    assign data_gnt  = data_win_s;
    assign fetch_gnt = fetch_win_s;

    // Memory command mux: only a data write uses the caller's byte enables;
    // every read drives full-word enables; an idle port is all zero.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_be    = 2'b00;
        mem_addr  = {ADDR_W{1'b0}};
        mem_wdata = {DATA_W{1'b0}};
        if (vga_win_s) begin
            mem_en   = 1'b1;
            mem_be   = 2'b11;
            mem_addr = vga_addr;
        end else if (data_win_s) begin
            mem_en    = 1'b1;
            mem_we    = data_we;
            mem_be    = data_we ? data_be : 2'b11;
            mem_addr  = data_addr;
            mem_wdata = data_wdata;
        end else if (fetch_win_s) begin
            mem_en   = 1'b1;
            mem_be   = 2'b11;
            mem_addr = fetch_addr;
        end else begin
            mem_en = 1'b0;
        end
    end

    // Next read owner: writes and idle cycles produce no return data.
    always_comb begin
        owner_d = OWN_NONE;
        if (vga_win_s) begin
            owner_d = OWN_VGA;
        end else if (data_win_s) begin
            owner_d = data_we ? OWN_NONE : OWN_DATA;
        end else if (fetch_win_s) begin
            owner_d = OWN_FETCH;
        end else begin
            owner_d = OWN_NONE;
        end
    end

    // Starvation counter: counts denied fetch cycles, saturating so that a
    // long VGA burst leaves fetch promoted but cannot overflow.
    always_comb begin
        starve_cnt_d = CNT_ZERO;
        if (fetch_req && !fetch_win_s) begin
            if (starve_cnt_q == CNT_MAX) begin
                starve_cnt_d = CNT_MAX;
            end else begin
                starve_cnt_d = starve_cnt_q + CNT_ONE;
            end
        end else begin
            starve_cnt_d = CNT_ZERO;
        end
    end

    // State registers; reset drops any read that was in flight.
    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            starve_cnt_q <= CNT_ZERO;
            owner_q      <= OWN_NONE;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            owner_q      <= owner_d;
        end
    end

    // Read return steering: only the owner sees valid/data, others read 0.
    always_comb begin
        vga_rvalid   = 1'b0;
        data_rvalid  = 1'b0;
        fetch_rvalid = 1'b0;
        case (owner_q)
            OWN_VGA:   vga_rvalid   = 1'b1;
            OWN_DATA:  data_rvalid  = 1'b1;
            OWN_FETCH: fetch_rvalid = 1'b1;
            default:   vga_rvalid   = 1'b0;
        endcase
    end

    assign vga_rdata   = vga_rvalid   ? mem_rdata : {DATA_W{1'b0}};
    assign data_rdata  = data_rvalid  ? mem_rdata : {DATA_W{1'b0}};
    assign fetch_rdata = fetch_rvalid ? mem_rdata : {DATA_W{1'b0}};

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Bench for mem_arbiter: a bench-side SRAM answers the memory port, a
// behavioural model (winner by priority list, integer starvation count, model
// memory image, pending-return record) predicts every output each cycle, and
// directed sequences pin specific literal values. Random traffic follows.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int ADDR_W = 13;
    localparam int DATA_W = 16;
    localparam int LIMIT  = 4;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk;
    logic              rst_async;
    logic              vga_req;
    logic [ADDR_W-1:0] vga_addr;
    logic              vga_gnt, vga_rvalid;
    logic [DATA_W-1:0] vga_rdata;
    logic              data_req, data_we;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] data_wdata;
    logic [1:0]        data_be;
    logic              data_gnt, data_rvalid;
    logic [DATA_W-1:0] data_rdata;
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_gnt, fetch_rvalid;
    logic [DATA_W-1:0] fetch_rdata;
    logic              mem_en, mem_we;
    logic [1:0]        mem_be;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    int n_chk  = 0;
    int n_pass = 0;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst_async(rst_async),
        .vga_req(vga_req), .vga_addr(vga_addr), .vga_gnt(vga_gnt),
        .vga_rvalid(vga_rvalid), .vga_rdata(vga_rdata),
        .data_req(data_req), .data_we(data_we), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_be(data_be), .data_gnt(data_gnt),
        .data_rvalid(data_rvalid), .data_rdata(data_rdata),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
        .fetch_rvalid(fetch_rvalid), .fetch_rdata(fetch_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Power-on content of any never-written word; address 5 holds 0xBEEF.
    function automatic logic [15:0] init_val(input logic [ADDR_W-1:0] a);
        if (a == 13'h0005) return 16'hBEEF;
        return 16'(32'(a) * 32'd40503) ^ 16'h5A5A;
    endfunction

    function automatic logic [15:0] merge(input logic [15:0] old_w,
                                          input logic [15:0] new_w,
                                          input logic [1:0] be);
        logic [15:0] r;
        r = old_w;
        if (be[0]) r[7:0]  = new_w[7:0];
        if (be[1]) r[15:8] = new_w[15:8];
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Bench SRAM driven by the DUT memory port; garbage on idle cycles.
    logic [15:0] sram [DEPTH];
    bit          sram_wr [DEPTH];
    always @(posedge clk) begin
        if (mem_en && mem_we) begin
            sram[mem_addr]    <= merge(sram_wr[mem_addr] ? sram[mem_addr] : init_val(mem_addr),
                                       mem_wdata, mem_be);
            sram_wr[mem_addr] <= 1'b1;
            mem_rdata         <= 16'($urandom);
        end else if (mem_en) begin
            mem_rdata <= sram_wr[mem_addr] ? sram[mem_addr] : init_val(mem_addr);
        end else begin
            mem_rdata <= 16'($urandom);
        end
    end

    // ------------------------------------------------------------------
    // Behavioural model and per-cycle compare (outputs sampled on negedge)
    // ------------------------------------------------------------------
    logic [15:0] m_mem [DEPTH];
    bit          m_wr  [DEPTH];

    initial begin : model
        int          m_cnt;
        int          m_pend;      // 0 none, 1 vga, 2 data, 3 fetch
        logic [15:0] m_pend_data;
        int          w;
        logic [ADDR_W-1:0] e_addr;
        logic        e_we;
        logic [1:0]  e_be;
        logic [15:0] e_wdata;
        logic [15:0] rd;
        m_cnt = 0;
        m_pend = 0;
        m_pend_data = 16'h0000;
        forever begin
            @(negedge clk);
            w = 0;
            if (!rst_async) begin
                if (vga_req)                          w = 1;
                else if (fetch_req && m_cnt >= LIMIT) w = 3;
                else if (data_req)                    w = 2;
                else if (fetch_req)                   w = 3;
            end
            e_addr  = (w == 1) ? vga_addr : (w == 2) ? data_addr : (w == 3) ? fetch_addr : 13'h0000;
            e_we    = (w == 2) && data_we;
            e_be    = (w == 0) ? 2'b00 : e_we ? data_be : 2'b11;
            e_wdata = (w == 2) ? data_wdata : 16'h0000;
            if (rst_async) m_pend = 0;

            chk("vga_gnt",   32'(vga_gnt),   32'(w == 1));
            chk("data_gnt",  32'(data_gnt),  32'(w == 2));
            chk("fetch_gnt", 32'(fetch_gnt), 32'(w == 3));
            chk("mem_en",    32'(mem_en),    32'(w != 0));
            chk("mem_we",    32'(mem_we),    32'(e_we));
            chk("mem_be",    32'(mem_be),    32'(e_be));
            chk("mem_addr",  32'(mem_addr),  32'(e_addr));
            chk("mem_wdata", 32'(mem_wdata), 32'(e_wdata));
            chk("vga_rvalid",   32'(vga_rvalid),   32'(m_pend == 1));
            chk("data_rvalid",  32'(data_rvalid),  32'(m_pend == 2));
            chk("fetch_rvalid", 32'(fetch_rvalid), 32'(m_pend == 3));
            chk("vga_rdata",   32'(vga_rdata),   (m_pend == 1) ? 32'(m_pend_data) : 32'h0);
            chk("data_rdata",  32'(data_rdata),  (m_pend == 2) ? 32'(m_pend_data) : 32'h0);
            chk("fetch_rdata", 32'(fetch_rdata), (m_pend == 3) ? 32'(m_pend_data) : 32'h0);

            // Advance the model to the state after the coming clock edge.
            if (rst_async) begin
                m_cnt  = 0;
                m_pend = 0;
            end else begin
                rd = m_wr[e_addr] ? m_mem[e_addr] : init_val(e_addr);
                if (e_we) begin
                    m_mem[e_addr] = merge(rd, data_wdata, data_be);
                    m_wr[e_addr]  = 1'b1;
                end
                m_pend      = (w == 0 || e_we) ? 0 : w;
                m_pend_data = rd;
                if (fetch_req && w != 3) m_cnt = (m_cnt + 1 > LIMIT) ? LIMIT : m_cnt + 1;
                else                     m_cnt = 0;
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Stimulus: directed sequences with literal checks, then random traffic
    // ------------------------------------------------------------------
    initial begin : stim
        bit gv, gd, gf;
        rst_async = 1'b1;
        vga_req = 1'b1;  vga_addr = 13'h0100;
        data_req = 1'b1; data_we = 1'b0; data_addr = 13'h0200;
        data_wdata = 16'h0000; data_be = 2'b11;
        fetch_req = 1'b1; fetch_addr = 13'h0300;

        // Reset with every request high: everything quiet.
        @(negedge clk);
        chk("rst_vga_gnt",   32'(vga_gnt),   32'h0);
        chk("rst_data_gnt",  32'(data_gnt),  32'h0);
        chk("rst_fetch_gnt", 32'(fetch_gnt), 32'h0);
        chk("rst_mem_en",    32'(mem_en),    32'h0);
        chk("rst_mem_we",    32'(mem_we),    32'h0);
        chk("rst_rvalid",    32'({vga_rvalid, data_rvalid, fetch_rvalid}), 32'h0);
        next_cycle();
        rst_async = 1'b0;
        @(negedge clk);
        chk("post_rst_vga_gnt", 32'(vga_gnt), 32'h1);
        next_cycle();
        vga_req = 1'b0; data_req = 1'b0; fetch_req = 1'b0;
        next_cycle();

        // Lone fetch read of address 5.
        fetch_req = 1'b1; fetch_addr = 13'h0005;
        @(negedge clk);
        chk("lone_fetch_gnt",  32'(fetch_gnt), 32'h1);
        chk("lone_fetch_addr", 32'(mem_addr),  32'h0005);
        next_cycle();
        fetch_req = 1'b0;
        @(negedge clk);
        chk("lone_fetch_rvalid", 32'(fetch_rvalid), 32'h1);
        chk("lone_fetch_rdata",  32'(fetch_rdata),  32'hBEEF);
        chk("lone_data_rvalid",  32'(data_rvalid),  32'h0);

        // Three-way contention, each dropping after its grant.
        next_cycle();
        vga_req = 1'b1; vga_addr = 13'h0010;
        data_req = 1'b1; data_we = 1'b0; data_addr = 13'h0011;
        fetch_req = 1'b1; fetch_addr = 13'h0012;
        @(negedge clk);
        chk("c3_0_vga_gnt", 32'({vga_gnt, data_gnt, fetch_gnt}), 32'h4);
        next_cycle();
        vga_req = 1'b0;
        @(negedge clk);
        chk("c3_1_data_gnt", 32'({vga_gnt, data_gnt, fetch_gnt}), 32'h2);
        chk("c3_1_vga_rvalid", 32'(vga_rvalid), 32'h1);
        next_cycle();
        data_req = 1'b0;
        @(negedge clk);
        chk("c3_2_fetch_gnt", 32'({vga_gnt, data_gnt, fetch_gnt}), 32'h1);
        chk("c3_2_data_rvalid", 32'({vga_rvalid, data_rvalid}), 32'h1);
        next_cycle();
        fetch_req = 1'b0;
        @(negedge clk);
        chk("c3_3_fetch_rvalid", 32'({data_rvalid, fetch_rvalid}), 32'h1);

        // Starvation: data and fetch held, fetch wins on the fifth cycle.
        next_cycle();
        data_req = 1'b1; fetch_req = 1'b1; fetch_addr = 13'h0020;
        for (int c = 0; c < 6; c++) begin
            data_addr = 13'(32 + c);
            @(negedge clk);
            chk("starve_data_gnt",  32'(data_gnt),  (c == 4) ? 32'h0 : 32'h1);
            chk("starve_fetch_gnt", 32'(fetch_gnt), (c == 4) ? 32'h1 : 32'h0);
            if (c == 5) chk("starve_cnt_cleared", 32'(dut.starve_cnt_q), 32'h0);
            next_cycle();
        end
        data_req = 1'b0; fetch_req = 1'b0;

        // Partial-byte write at the top address.
        data_req = 1'b1; data_we = 1'b1; data_be = 2'b10;
        data_addr = 13'h1FFF; data_wdata = 16'h12AB;
        @(negedge clk);
        chk("bw_mem_en",    32'(mem_en),    32'h1);
        chk("bw_mem_we",    32'(mem_we),    32'h1);
        chk("bw_mem_be",    32'(mem_be),    32'h2);
        chk("bw_mem_addr",  32'(mem_addr),  32'h1FFF);
        chk("bw_mem_wdata", 32'(mem_wdata), 32'h12AB);
        next_cycle();
        data_req = 1'b0; data_we = 1'b0; data_be = 2'b11;
        @(negedge clk);
        chk("bw_no_rvalid", 32'(data_rvalid), 32'h0);

        // VGA burst holds off starved fetch; fetch then beats data.
        next_cycle();
        vga_req = 1'b1; vga_addr = 13'h0040; fetch_req = 1'b1; data_req = 1'b1;
        data_addr = 13'h0041; fetch_addr = 13'h0042;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("vga_burst_vga_gnt",   32'(vga_gnt),   32'h1);
            chk("vga_burst_fetch_gnt", 32'(fetch_gnt), 32'h0);
            if (c == 9) chk("vga_burst_cnt_sat", 32'(dut.starve_cnt_q), 32'h4);
            next_cycle();
        end
        vga_req = 1'b0;
        @(negedge clk);
        chk("after_vga_fetch_gnt", 32'(fetch_gnt), 32'h1);
        chk("after_vga_data_gnt",  32'(data_gnt),  32'h0);
        next_cycle();
        fetch_req = 1'b0;
        @(negedge clk);
        chk("pre_rst_data_gnt", 32'(data_gnt), 32'h1);
        next_cycle();
        rst_async = 1'b1; data_req = 1'b0;
        @(negedge clk);
        chk("rst_mid_read_rvalid", 32'(data_rvalid), 32'h0);
        next_cycle();
        rst_async = 1'b0;
        @(negedge clk);
        chk("post_rst_no_reissue", 32'(data_rvalid), 32'h0);
        next_cycle();

        // Random traffic: requesters hold until granted, sometimes give up.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            gv = vga_gnt; gd = data_gnt; gf = fetch_gnt;
            next_cycle();
            rst_async = ($urandom_range(0, 249) == 0);
            if (!vga_req || gv) begin
                vga_req  = ($urandom_range(0, 99) < 20);
                vga_addr = ($urandom_range(0, 7) == 0) ? 13'h1FFF : 13'($urandom_range(0, 63));
            end else if ($urandom_range(0, 15) == 0) begin
                vga_req = 1'b0;
            end
            if (!data_req || gd) begin
                data_req   = ($urandom_range(0, 99) < 60);
                data_we    = $urandom_range(0, 1) == 1;
                data_be    = 2'($urandom_range(0, 3));
                data_wdata = 16'($urandom);
                data_addr  = ($urandom_range(0, 7) == 0) ? 13'h1FFF : 13'($urandom_range(0, 63));
            end else if ($urandom_range(0, 15) == 0) begin
                data_req = 1'b0;
            end
            if (!fetch_req || gf) begin
                fetch_req  = ($urandom_range(0, 99) < 60);
                fetch_addr = ($urandom_range(0, 7) == 0) ? 13'h1FFF : 13'($urandom_range(0, 63));
            end else if ($urandom_range(0, 15) == 0) begin
                fetch_req = 1'b0;
            end
        end
        rst_async = 1'b0;
        @(negedge clk);
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
